// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED command sequencer:
//   - ROM word width and field layout ({op[1:0], arg[7:0]})
//   - script opcodes (CMD / DATA / DELAY / END)
//   - sequencer FSM state encodings
//   - helper to classify opcodes that put a byte on the bus
// ---------------------------------------------------------------------------
package oled_pkg;

  localparam int ROM_W = 10;

  typedef enum logic [1:0] {
    OP_CMD   = 2'b00,
    OP_DATA  = 2'b01,
    OP_DELAY = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_SEND   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_DELAY  = 4'd5,
    ST_NEXT   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } state_e;

  // CMD and DATA entries both produce one byte on the driver.
  function automatic logic is_byte_op(input op_e op);
    return (op == OP_CMD) || (op == OP_DATA);
  endfunction

endpackage

// File: rtl/oled_seq_delay.sv
// ---------------------------------------------------------------------------
// oled_seq_delay
// Loadable down-counter used for DELAY script entries.
//   clk      in   system clock
//   rst      in   async active-high reset
//   load_i   in   load value_i into the counter (has priority over tick_i)
//   tick_i   in   decrement by one (holds at zero)
//   value_i  in   W-bit load value
//   zero_o   out  counter currently equals zero
// ---------------------------------------------------------------------------
module oled_seq_delay #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         tick_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/oled_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// oled_cmd_sequencer
// Walks a script held in an external synchronous ROM and feeds it byte by
// byte to an I2C driver. Entries are CMD (dc=0), DATA (dc=1), DELAY
// (arg*DLY_UNIT idle cycles) or END. NACKed bytes are resent up to
// MAX_RETRY times before the run aborts. A start pulse replays the script
// from BASE_ADDR whenever the sequencer is not busy.
//   clk        in   system clock
//   rst        in   async active-high reset
//   start      in   1-cycle pulse: run script from BASE_ADDR
//   rom_addr   out  ROM address (registered)
//   rom_data   in   {op[1:0], arg[7:0]}, valid 1 clk after rom_addr
//   iic_din    out  byte to driver (registered)
//   iic_dc     out  0=command, 1=data (registered)
//   iic_start  out  1-cycle pulse to driver (registered)
//   iic_done   in   1-cycle pulse: byte finished
//   iic_err    in   NACK flag, qualified by iic_done
//   busy       out  sequencer running
//   done       out  level: last run completed
//   err        out  level: last run aborted
// ---------------------------------------------------------------------------
module oled_cmd_sequencer
  import oled_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int SEQ_LEN   = 31,
  parameter int BASE_ADDR = 0,
  parameter int DLY_UNIT  = 1000,
  parameter int DLY_W     = 18,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [7:0]        iic_din,
  output logic              iic_dc,
  output logic              iic_start,
  input  logic              iic_done,
  input  logic              iic_err,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [7:0]        iic_din_q, iic_din_d;
  logic              iic_dc_q, iic_dc_d;
  logic              iic_start_q, iic_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  op_e               op_s;
  logic [7:0]        arg_s;
  logic              dly_load_s;
  logic              dly_tick_s;
  logic              dly_zero_s;
  logic [DLY_W-1:0]  dly_value_s;

  assign op_s  = op_e'(rom_data[9:8]);
  assign arg_s = rom_data[7:0];

  // DELAY occupies exactly arg*DLY_UNIT cycles: counting from N-1 down to 0.
  assign dly_value_s = DLY_W'((32'(arg_s) * 32'(DLY_UNIT)) - 32'd1);
  assign dly_tick_s  = (state_q == ST_DELAY) && !dly_zero_s;

  oled_seq_delay #(
    .W (DLY_W)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .load_i  (dly_load_s),
    .tick_i  (dly_tick_s),
    .value_i (dly_value_s),
    .zero_o  (dly_zero_s)
  );

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    iic_din_d   = iic_din_q;
    iic_dc_d    = iic_dc_q;
    iic_start_d = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    dly_load_s  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_FETCH;
          rom_addr_d = ADDR_W'(BASE_ADDR);
          idx_d      = '0;
          retry_d    = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_byte_op(op_s)) begin
          iic_din_d   = arg_s;
          iic_dc_d    = (op_s == OP_DATA);
          iic_start_d = 1'b1;  // pulse is visible during SEND
          state_d     = ST_SEND;
        end else if (op_s == OP_DELAY) begin
          if (arg_s != 8'd0) begin
            dly_load_s = 1'b1;
            state_d    = ST_DELAY;
          end else begin
            state_d = ST_NEXT;
          end
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (iic_done) begin
          if (!iic_err) begin
            retry_d = '0;
            state_d = ST_NEXT;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d     = retry_q + RTY_W'(1);
            iic_start_d = 1'b1;  // resend the same latched byte
            state_d     = ST_SEND;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DELAY: begin
        if (dly_zero_s) begin
          state_d = ST_NEXT;
        end else begin
          state_d = ST_DELAY;
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_W'(SEQ_LEN - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          rom_addr_d = rom_addr_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= ADDR_W'(BASE_ADDR);
      idx_q       <= '0;
      retry_q     <= '0;
      iic_din_q   <= 8'd0;
      iic_dc_q    <= 1'b0;
      iic_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      iic_din_q   <= iic_din_d;
      iic_dc_q    <= iic_dc_d;
      iic_start_q <= iic_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign iic_din   = iic_din_q;
  assign iic_dc    = iic_dc_q;
  assign iic_start = iic_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
